adder_share_arbiter: RTL and testbench

//  Shares one 32-bit ripple-carry adder among NREQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Operands are registered before the adder and the result is registered after it, so the long carry chain sits alone in one cycle.
//  - Result returns on a valid/ready channel tagged with the requester id.
//  - Sits between requesting datapath units and the adder instance.

---
 rtl/adder_share_pkg.sv | 17 +
 rtl/rca32.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/adder_share_arbiter.sv | 137 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the adder-sharing arbiter: operand width, FSM states and the registered result bundle.
package adder_share_pkg;
    localparam int ADD_W    = 32;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;
endpackage

// File: rtl/rca32.sv
// Plain 32-bit ripple-carry adder: sum/cout from a, b, cin.
// Purely combinational; no flow control.
module rca32
    import adder_share_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);
    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < ADD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
// Combinational; the caller decides when the grant is honoured.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            gnt_vld,
    output logic [IDW-1:0]  gnt_id,
    output logic [NREQ-1:0] gnt
);
    int idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        gnt = '0;
        if (gnt_vld) gnt[gnt_id] = 1'b1;
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one registered-in/registered-out 32-bit adder among NREQ requesters, round-robin (ADDSHARE_SUB_EN adds subtract).
// Latency: accept at cycle N, rsp_valid at N+2; at most one op in flight, 3 cycles minimum per op.
// Backpressure: a stalled rsp_ready holds the FSM in RESP, so req_ready stays 0 for every requester.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
`ifdef ADDSHARE_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [ADD_W-1:0] op_a_q, op_a_d;
    logic [ADD_W-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    res_t             res_q, res_d;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic [NREQ-1:0]  gnt;
    logic [ADD_W-1:0] sel_b;
    logic             sel_cin;
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .gnt     (gnt)
    );

    rca32 u_add (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (op_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Subtraction is folded in before the operand register: A + ~B + 1.
    always_comb begin
        sel_b   = req_b[ADD_W*int'(gnt_id) +: ADD_W];
        sel_cin = req_cin[gnt_id];
`ifdef ADDSHARE_SUB_EN
        if (req_sub[gnt_id]) begin
            sel_b   = ~sel_b;
            sel_cin = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld)   state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        id_d     = id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        res_d    = res_q;
        if (state_q == IDLE && gnt_vld) begin
            id_d     = gnt_id;
            op_a_d   = req_a[ADD_W*int'(gnt_id) +: ADD_W];
            op_b_d   = sel_b;
            op_cin_d = sel_cin;
        end
        if (state_q == EXEC) begin
            res_d.sum  = add_sum;
            res_d.cout = add_cout;
            res_d.ovf  = (op_a_q[ADD_W-1] == op_b_q[ADD_W-1]) && (add_sum[ADD_W-1] != op_a_q[ADD_W-1]);
        end
        if (state_q == RESP && rsp_ready) begin
            ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : IDW'(id_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            res_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? gnt : '0;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        rsp_sum   = res_q.sum;
        rsp_cout  = res_q.cout;
        rsp_ovf   = res_q.ovf;
        rsp_id    = id_q;
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a cycle-level reference model checked every negedge.
module tb_adder_share_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_cin = '0;
    logic [3:0]   req_sub = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic [1:0]   rsp_id;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    adder_share_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDSHARE_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Reference model: one op at a time, response two edges after acceptance.
    int          m_inflight = 0;
    int          m_age      = 0;
    int          m_ptr      = 0;
    int          m_id       = 0;
    logic [31:0] m_a        = '0;
    logic [31:0] m_b        = '0;
    logic        m_cin      = 1'b0;
    int          g;
    logic [3:0]  e_ready;
    logic        e_rv;
    logic [32:0] e_u;
    longint      a_l, b_l, c_l, s_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_inflight = 0;
            m_age      = 0;
            m_ptr      = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            chk("rst_rsp_ovf", rsp_ovf, 0);
            chk("rst_rsp_id", rsp_id, 0);
        end else begin
            g       = (m_inflight != 0) ? -1 : pick(req_valid, m_ptr);
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            e_rv = (m_inflight != 0) && (m_age >= 2);
            chk("req_ready", req_ready, e_ready);
            chk("busy", busy, m_inflight != 0);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) begin
                e_u = {1'b0, m_a} + {1'b0, m_b} + {32'b0, m_cin};
                a_l = $signed(m_a);
                b_l = $signed(m_b);
                c_l = m_cin;
                s_l = a_l + b_l + c_l;
                chk("rsp_sum", rsp_sum, e_u[31:0]);
                chk("rsp_cout", rsp_cout, e_u[32]);
                chk("rsp_ovf", rsp_ovf, (s_l > 64'sd2147483647) || (s_l < -64'sd2147483648));
                chk("rsp_id", rsp_id, m_id);
            end
            if (g >= 0) begin
                m_inflight = 1;
                m_age      = 1;
                m_id       = g;
                m_a        = req_a[32*g +: 32];
                m_b        = req_b[32*g +: 32];
                m_cin      = req_cin[g];
`ifdef ADDSHARE_SUB_EN
                if (req_sub[g]) begin
                    m_b   = ~m_b;
                    m_cin = 1'b1;
                end
`endif
            end else if (m_inflight != 0 && m_age < 2) begin
                m_age++;
            end else if (e_rv && rsp_ready) begin
                m_inflight = 0;
                m_ptr      = (m_id + 1) % 4;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("accept_seen", req_ready[i], 1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, output logic [31:0] s, output logic co, output logic ov,
                         output logic [1:0] id, output int lat);
        int t0;
        @(posedge clk); #1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = cin;
        req_sub[i]        = sub;
        req_valid[i]      = 1'b1;
        rsp_ready         = 1'b1;
        wait_ready(i);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        wait_rsp();
        lat = cyc - t0;
        s   = rsp_sum;
        co  = rsp_cout;
        ov  = rsp_ovf;
        id  = rsp_id;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    logic [31:0] s;
    logic        co, ov;
    logic [1:0]  id;
    int          lat;
    int          ids[5];
    int          cycs[5];

    initial begin
        @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Carry out of bit 31, and the accept-to-response latency.
        do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, ov, id, lat);
        chk("t1_sum", s, 32'h0);
        chk("t1_cout", co, 1);
        chk("t1_ovf", ov, 0);
        chk("t1_id", id, 0);
        chk("t1_latency", lat, 2);

        // Signed overflow cases and carry-in.
        do_op(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, ov, id, lat);
        chk("t4a_sum", s, 32'h8000_0000);
        chk("t4a_ovf", ov, 1);
        chk("t4a_cout", co, 0);
        do_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, s, co, ov, id, lat);
        chk("t4b_sum", s, 32'h0);
        chk("t4b_cout", co, 1);
        chk("t4b_ovf", ov, 1);
        do_op(3, 32'h10, 32'h20, 1'b1, 1'b0, s, co, ov, id, lat);
        chk("t4c_sum", s, 32'h31);
        chk("t4c_id", id, 3);

        // Round-robin with every requester valid continuously.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h1000 * i;
            req_b[32*i +: 32] = i + 1;
            req_cin[i]        = 1'b0;
            req_sub[i]        = 1'b0;
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_rsp();
            ids[r]  = rsp_id;
            cycs[r] = cyc;
            if (r == 1) chk("t2_sum_id1", rsp_sum, 32'h1002);
        end
        chk("t2_id0", ids[0], 0);
        chk("t2_id1", ids[1], 1);
        chk("t2_id2", ids[2], 2);
        chk("t2_id3", ids[3], 3);
        chk("t2_id4", ids[4], 0);
        for (int r = 1; r < 5; r++) chk("t2_period", cycs[r] - cycs[r-1], 3);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(6);

        // Stalled consumer holds the response and blocks all requesters.
        do_reset();
        rsp_ready = 1'b0;
        req_a[96 +: 32] = 32'h1234;
        req_b[96 +: 32] = 32'h1111;
        req_cin[3]      = 1'b0;
        req_valid       = 4'b1000;
        wait_ready(3);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            chk("t3_rsp_valid", rsp_valid, 1);
            chk("t3_sum", rsp_sum, 32'h2345);
            chk("t3_id", rsp_id, 3);
            chk("t3_req_ready", req_ready, 0);
            chk("t3_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_hs_valid", rsp_valid, 1);
        @(negedge clk);
        chk("t3_after_busy", busy, 0);
        chk("t3_wrap_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(6);

        // Reset while an op is in EXEC drops it with no response.
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_ready(2);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_no_rsp", rsp_valid, 0);
            chk("t5_idle", busy, 0);
        end
        @(posedge clk); #1;
        req_valid = 4'b0101;
        @(negedge clk);
        chk("t5_grant0", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        idle_cycles(6);

`ifdef ADDSHARE_SUB_EN
        do_op(0, 32'h5, 32'h7, 1'b0, 1'b1, s, co, ov, id, lat);
        chk("t6a_sum", s, 32'hFFFF_FFFE);
        chk("t6a_cout", co, 0);
        do_op(1, 32'h7, 32'h5, 1'b0, 1'b1, s, co, ov, id, lat);
        chk("t6b_sum", s, 32'h2);
        chk("t6b_cout", co, 1);
        do_op(2, 32'h0, 32'h8000_0000, 1'b0, 1'b1, s, co, ov, id, lat);
        chk("t6c_sum", s, 32'h8000_0000);
        chk("t6c_ovf", ov, 1);
        idle_cycles(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
